uart_tx_serializer: RTL and testbench

//  Serial UART transmitter directly downstream of the TX control/sequence logic.

---
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx_serializer.sv | 129 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake between the TX control logic and the UART serializer.
// The master drives the byte and start strobe; the slave reports line, busy and frame-done.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (output tx_data, tx_start, input tx, busy, tx_done);
  modport slave  (input tx_data, tx_start, output tx, busy, tx_done);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered; the start bit is driven on the accepting edge itself.
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset,
  uart_tx_if.slave   bus
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CW         = $clog2(BIT_CYCLES + 1);
  localparam bit PAR_EN     = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD    = (PARITY == 2);
  localparam bit TWO_STOP   = (STOP_BITS == 2);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  generate
    if (BIT_CYCLES < 1) begin : g_bad_baud
      $error("uart_tx_serializer: CLK_FREQ/BAUD_RATE must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic          stop_idx, stop_idx_n;
  logic [7:0]    sh, sh_n;
  logic          par, par_n;
  logic          tx_q, tx_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          bit_end;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      sh       <= '0;
      par      <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      stop_idx <= stop_idx_n;
      sh       <= sh_n;
      par      <= par_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Every output is computed one edge ahead so tx changes exactly on bit boundaries.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    stop_idx_n = stop_idx;
    sh_n       = sh;
    par_n      = par;
    tx_n       = tx_q;
    busy_n     = busy_q;
    done_n     = 1'b0;

    if (state != S_IDLE) cnt_n = bit_end ? '0 : cnt + CW'(1);

    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (bus.tx_start) begin
          sh_n       = bus.tx_data;
          par_n      = PAR_ODD ? ~^bus.tx_data : ^bus.tx_data;
          idx_n      = '0;
          stop_idx_n = 1'b0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
          state_n    = S_START;
        end
      end
      S_START: if (bit_end) begin
        tx_n    = sh[0];
        sh_n    = {1'b0, sh[7:1]};
        state_n = S_DATA;
      end
      S_DATA: if (bit_end) begin
        if (idx == 3'd7) begin
          tx_n    = PAR_EN ? par : 1'b1;
          state_n = PAR_EN ? S_PARITY : S_STOP;
        end else begin
          tx_n  = sh[0];
          sh_n  = {1'b0, sh[7:1]};
          idx_n = idx + 3'd1;
        end
      end
      S_PARITY: if (bit_end) begin
        tx_n    = 1'b1;
        state_n = S_STOP;
      end
      S_STOP: if (bit_end) begin
        if (!TWO_STOP || stop_idx) begin
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          stop_idx_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: four serializer instances (8N1, even, odd, 8N2) at 16 clocks per bit.
// Line bits are sampled mid-bit and compared against hand-packed frames (bit k = k-th on the line).
module tb_uart_tx_serializer;
  localparam int NI = 4;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [NI-1:0]          st    = '0;
  logic [NI-1:0][7:0]     dat   = '0;
  logic [NI-1:0]          txw, bw, dw;
  int                     n_chk = 0;
  int                     n_err = 0;

  always #5 clock = ~clock;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      localparam int P = (g == 1) ? 1 : (g == 2) ? 2 : 0;
      localparam int S = (g == 3) ? 2 : 1;
      uart_tx_if bus();
      assign bus.tx_data  = dat[g];
      assign bus.tx_start = st[g];
      assign txw[g]       = bus.tx;
      assign bw[g]        = bus.busy;
      assign dw[g]        = bus.tx_done;
      uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(P), .STOP_BITS(S)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse tx_start for one rising edge; returns on the negedge just after the accepting edge.
  task automatic send(input int i, input logic [7:0] d);
    @(negedge clock);
    dat[i] = d;
    st[i]  = 1'b1;
    @(negedge clock);
    st[i]  = 1'b0;
  endtask

  // Starts at the negedge after the accepting edge (n=0) and walks n=0..len.
  task automatic frame_chk(input int i, input int nbits, input logic [11:0] exp, input int len,
                           input int inj_at, input logic [7:0] inj_d, input string tag);
    logic [11:0] got = '0;
    int busy_n = 0, done_n = 0, done_at = -1;
    for (int n = 0; n <= len; n++) begin
      if (n % 16 == 7 && n / 16 < nbits) got[n/16] = txw[i];
      if (bw[i]) busy_n++;
      if (dw[i]) begin done_n++; done_at = n; end
      if (inj_at >= 0 && n == inj_at) begin dat[i] = inj_d; st[i] = 1'b1; end
      else if (inj_at >= 0 && n == inj_at + 1) st[i] = 1'b0;
      @(negedge clock);
    end
    chk({tag, "_bits"}, 32'(got), 32'(exp));
    chk({tag, "_busy_len"}, busy_n, len);
    chk({tag, "_done_cnt"}, done_n, 1);
    chk({tag, "_done_at"}, done_at, len);
  endtask

  task automatic idle_chk(input int i, input int cycles, input string tag);
    int bad = 0;
    for (int c = 0; c < cycles; c++) begin
      if (txw[i] !== 1'b1 || bw[i] !== 1'b0 || dw[i] !== 1'b0) bad++;
      @(negedge clock);
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int dn;
    // Reset held for 3 clocks, then released: outputs must not move.
    repeat (3) @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_tx%0d", i), 32'(txw[i]), 1);
      chk($sformatf("rst_busy%0d", i), 32'(bw[i]), 0);
      chk($sformatf("rst_done%0d", i), 32'(dw[i]), 0);
    end
    reset = 1'b1;
    for (int i = 0; i < NI; i++) idle_chk(i, 8, $sformatf("rel_idle%0d", i));

    // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5);
    frame_chk(0, 10, 12'b00_1101001010, 160, -1, 8'h00, "a5_8n1");
    idle_chk(0, 20, "a5_after");

    // Even parity 0x07 -> parity 1; odd -> parity 0
    send(1, 8'h07);
    frame_chk(1, 11, 12'b0_11000001110, 176, -1, 8'h00, "even_07");
    send(2, 8'h07);
    frame_chk(2, 11, 12'b0_10000001110, 176, -1, 8'h00, "odd_07");

    // tx_start with 0x55 mid-frame is ignored and not queued
    send(0, 8'hA5);
    frame_chk(0, 10, 12'b00_1101001010, 160, 40, 8'h55, "ign_a5");
    idle_chk(0, 40, "ign_no_second");

    // tx_start held through frame end, 8N2 0x3C: back-to-back with 1 idle clock
    @(negedge clock);
    dat[3] = 8'h3C;
    st[3]  = 1'b1;
    @(negedge clock);
    frame_chk(3, 11, 12'b0_11001111000, 176, -1, 8'h00, "b2b_f1");
    chk("b2b_restart_tx", 32'(txw[3]), 0);
    chk("b2b_restart_busy", 32'(bw[3]), 1);
    st[3] = 1'b0;
    frame_chk(3, 11, 12'b0_11001111000, 176, -1, 8'h00, "b2b_f2");
    idle_chk(3, 20, "b2b_after");

    // Async reset at clock 70 of a frame
    send(0, 8'hA5);
    repeat (70) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    chk("midrst_tx", 32'(txw[0]), 1);
    chk("midrst_busy", 32'(bw[0]), 0);
    dn = 0;
    repeat (3) begin
      @(negedge clock);
      if (dw[0]) dn++;
    end
    chk("midrst_no_done", dn, 0);
    reset = 1'b1;
    idle_chk(0, 10, "midrst_idle");
    // 0x5A: line 0,0,1,0,1,1,0,1,0,1
    send(0, 8'h5A);
    frame_chk(0, 10, 12'b00_1010110100, 160, -1, 8'h00, "post_rst_5a");
    idle_chk(0, 10, "post_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
